// File: rtl/darkbus_pkg.sv
// darkbus_pkg
//   Shared definitions for the darkbus RAM consumer slice: bus data width,
//   number of byte lanes, and the transaction FSM state type.
package darkbus_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  // IDLE samples requests, WAIT burns the configured wait cycles,
  // ACK is the single cycle in which the memory access happens.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/darkbus_if.sv
// darkbus_if
//   Darkbus signal bundle.
//   EN   : request qualifier (address already decoded upstream)
//   RE   : read request
//   WE   : write request
//   BE   : byte-lane enables for writes, bit n covers DATA[8n+7:8n]
//   ADDR : byte address
//   DATA : shared tri-state data, producer drives on writes, consumer on reads
//   RACK : read acknowledge
//   WACK : write acknowledge
interface darkbus_if;

  import darkbus_pkg::DATA_W;
  import darkbus_pkg::LANES;

  logic              EN;
  logic              RE;
  logic              WE;
  logic [LANES-1:0]  BE;
  logic [31:0]       ADDR;
  wire  [DATA_W-1:0] DATA;
  logic              RACK;
  logic              WACK;

  modport consumer (
    input  EN, RE, WE, BE, ADDR,
    inout  DATA,
    output RACK, WACK
  );

  modport producer (
    output EN, RE, WE, BE, ADDR,
    inout  DATA,
    input  RACK, WACK
  );

endinterface

// File: rtl/darkbus_ram_array.sv
// darkbus_ram_array
//   Single-port synchronous word RAM with per-byte write enables.
//   No reset: contents are undefined until written.
//   clock     : rising-edge clock
//   enable    : perform an access on this edge
//   writeEn   : access is a write (only lanes with laneEn set change)
//   laneEn    : byte-lane write enables
//   addr      : word address
//   writeData : write word
//   readData  : registered word at addr, updated on every enabled access
module darkbus_ram_array
  import darkbus_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              clock,
  input  logic              enable,
  input  logic              writeEn,
  input  logic [LANES-1:0]  laneEn,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // One shared port: an enabled edge writes the selected lanes and also
  // registers the word as it was before this edge. The consumer only looks
  // at readData after read accesses, so the read-before-write value of a
  // write access is never used.
  always_ff @(posedge clock) begin
    if (enable) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (writeEn && laneEn[lane]) begin
          mem[addr][8*lane +: 8] <= writeData[8*lane +: 8];
        end
      end
      readData <= mem[addr];
    end
  end

endmodule

// File: rtl/darkbus_ram_cons.sv
// darkbus_ram_cons
//   Darkbus consumer that fronts a 2^AWIDTH x 32-bit RAM and answers each
//   request after WAIT extra cycles with a one-cycle RACK or WACK.
//   Parameters:
//     AWIDTH : word-address bits (byte address bits AWIDTH+1:2 are used)
//     WAIT   : wait cycles before each acknowledge, 0..15
//   Ports:
//     CLK : clock, everything on the rising edge
//     RES : asynchronous active-high reset
//     BUS : darkbus consumer modport
module darkbus_ram_cons #(
  parameter int AWIDTH = 10,
  parameter int WAIT   = 1
) (
  input logic         CLK,
  input logic         RES,
  darkbus_if.consumer BUS
);

  // WAIT is both the parameter name and a state name, so the state
  // literal is always written package-qualified below.
  import darkbus_pkg::state_t;
  import darkbus_pkg::IDLE;
  import darkbus_pkg::ACK;
  import darkbus_pkg::DATA_W;
  import darkbus_pkg::LANES;

  localparam logic [3:0] WAIT_COUNT = 4'(WAIT);

  state_t            state;
  state_t            nextState;
  logic [3:0]        waitCount;
  logic [AWIDTH-1:0] capAddr;
  logic [LANES-1:0]  capBe;
  logic [DATA_W-1:0] capData;
  logic              capWrite;
  logic              rackReg;
  logic              wackReg;
  logic              request;
  logic              memEnable;
  logic              memWrite;
  logic [AWIDTH-1:0] memAddr;
  logic [LANES-1:0]  memLanes;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;
  logic              unusedAddrBits;

  // A request needs the qualifier plus at least one operation; RE and WE
  // together count as a write.
  assign request = BUS.EN && (BUS.RE || BUS.WE);

  // Address bits outside the word index are ignored, which makes the
  // memory alias every 4*2^AWIDTH bytes.
  assign unusedAddrBits = ^{BUS.ADDR[31:AWIDTH+2], BUS.ADDR[1:0]};

  // State register; reset drops any transaction in flight at once.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE. In WAIT a
  // dropped EN aborts, otherwise ACK is entered on the edge where the
  // counter steps from 1 to 0. ACK always lasts one cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (request) begin
          nextState = (WAIT == 0) ? ACK : darkbus_pkg::WAIT;
        end
      end
      darkbus_pkg::WAIT: begin
        if (!BUS.EN) begin
          nextState = IDLE;
        end else if (waitCount == 4'd1) begin
          nextState = ACK;
        end
      end
      ACK: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Capture the whole request when it is accepted so later bus changes
  // cannot disturb it, and count down the wait cycles while in WAIT.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      waitCount <= '0;
      capAddr   <= '0;
      capBe     <= '0;
      capData   <= '0;
      capWrite  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            waitCount <= WAIT_COUNT;
            capAddr   <= BUS.ADDR[AWIDTH+1:2];
            capBe     <= BUS.BE;
            capData   <= BUS.DATA;
            capWrite  <= BUS.WE;
          end
        end
        darkbus_pkg::WAIT: begin
          waitCount <= waitCount - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // The RAM is accessed on the edge that enters ACK. With WAIT=0 that is
  // the same edge that captures the request, so in IDLE the live bus
  // values are fed straight through instead of the capture registers.
  always_comb begin
    memEnable    = (nextState == ACK) && !RES;
    memWrite     = capWrite;
    memAddr      = capAddr;
    memLanes     = capBe;
    memWriteData = capData;
    if (state == IDLE) begin
      memWrite     = BUS.WE;
      memAddr      = BUS.ADDR[AWIDTH+1:2];
      memLanes     = BUS.BE;
      memWriteData = BUS.DATA;
    end
  end

  darkbus_ram_array #(
    .AWIDTH(AWIDTH)
  ) ramArray (
    .clock    (CLK),
    .enable   (memEnable),
    .writeEn  (memWrite),
    .laneEn   (memLanes),
    .addr     (memAddr),
    .writeData(memWriteData),
    .readData (memReadData)
  );

  // Acknowledges are registered off the ACK state, so they appear in the
  // cycle after ACK while the RAM output still holds the fetched word.
  // Being flops with async reset, they vanish the moment RES rises.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      rackReg <= 1'b0;
      wackReg <= 1'b0;
    end else begin
      rackReg <= (state == ACK) && !capWrite;
      wackReg <= (state == ACK) && capWrite;
    end
  end

  assign BUS.RACK = rackReg;
  assign BUS.WACK = wackReg;

  // The data bus is only ever driven in the RACK cycle.
  assign BUS.DATA = rackReg ? memReadData : {DATA_W{1'bz}};

endmodule

// File: tb/tb_darkbus_ram_cons.sv
// tb_darkbus_ram_cons
//   Bench for darkbus_ram_cons: one instance with WAIT=2 and one with
//   WAIT=0 (AWIDTH=10 for both) share clock and reset; sel chooses which
//   instance receives EN and which outputs are observed. A word-level
//   memory model keyed by instance and wrapped word index supplies the
//   expected read data. While the DUT should not be driving DATA the bench
//   drives a known value and expects to read exactly that value back.
module tb_darkbus_ram_cons;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic        CLK = 1'b0;
  logic        RES;
  logic        sel;
  logic        en;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] tbData;
  logic        tbDrive;

  logic        rackObs;
  logic        wackObs;
  logic [31:0] dataObs;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];
  logic [31:0] pool [8];

  always #5 CLK = ~CLK;

  darkbus_if busW2();
  darkbus_if busW0();

  assign busW2.EN   = en & ~sel;
  assign busW2.RE   = re;
  assign busW2.WE   = we;
  assign busW2.BE   = be;
  assign busW2.ADDR = addr;
  assign busW2.DATA = tbDrive ? tbData : 32'hzzzz_zzzz;

  assign busW0.EN   = en & sel;
  assign busW0.RE   = re;
  assign busW0.WE   = we;
  assign busW0.BE   = be;
  assign busW0.ADDR = addr;
  assign busW0.DATA = tbDrive ? tbData : 32'hzzzz_zzzz;

  assign rackObs = sel ? busW0.RACK : busW2.RACK;
  assign wackObs = sel ? busW0.WACK : busW2.WACK;
  assign dataObs = sel ? busW0.DATA : busW2.DATA;

  darkbus_ram_cons #(.AWIDTH(AW), .WAIT(2)) dut (
    .CLK(CLK),
    .RES(RES),
    .BUS(busW2)
  );

  darkbus_ram_cons #(.AWIDTH(AW), .WAIT(0)) dutZero (
    .CLK(CLK),
    .RES(RES),
    .BUS(busW0)
  );

  // Word slot addressed by a byte address, separate per instance.
  function automatic int keyOf(input logic s, input logic [31:0] a);
    return (s ? 4096 : 0) + int'((a / 32'd4) % 32'(WORDS));
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                             input logic [31:0] nw,
                                             input logic [3:0] lanes);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) begin
      if (lanes[l]) r[8*l +: 8] = nw[8*l +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs for n cycles expecting no acknowledge and an undriven DUT side.
  task automatic idleCycles(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      checkOutput($sformatf("%s rack c%0d", tag, j), 32'(rackObs), 32'd0);
      checkOutput($sformatf("%s wack c%0d", tag, j), 32'(wackObs), 32'd0);
      checkOutput($sformatf("%s data c%0d", tag, j), dataObs, tbData);
    end
  endtask

  // One bus transaction on the selected instance. Acknowledge is expected
  // 1+WAIT edges after the request edge. abortAt/resetAt (-1 = off) drop
  // EN or pulse RES after the checks of that cycle. useExp overrides the
  // model's expected read word.
  task automatic applyStimulus(input string tag, input logic doRe, input logic doWe,
                               input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d, input int abortAt,
                               input int resetAt, input bit useExp,
                               input logic [31:0] expRead);
    int          lat;
    int          key;
    bit          isRead;
    bit          isWrite;
    bit          known;
    bit          live;
    bit          expAck;
    logic [31:0] expRd;
    lat     = sel ? 1 : 3;
    isRead  = doRe && !doWe;
    isWrite = doWe;
    key     = keyOf(sel, a);
    known   = useExp || model.exists(key);
    expRd   = useExp ? expRead : (model.exists(key) ? model[key] : 32'd0);
    live    = 1'b1;
    @(negedge CLK);
    en = 1'b1; re = doRe; we = doWe; addr = a; be = b;
    tbData = d; tbDrive = !isRead;
    for (int j = 0; j <= lat + 1; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      expAck = live && (j == lat);
      checkOutput($sformatf("%s rack c%0d", tag, j), 32'(rackObs), 32'(expAck && isRead));
      checkOutput($sformatf("%s wack c%0d", tag, j), 32'(wackObs), 32'(expAck && isWrite));
      if (expAck && isRead) begin
        if (known) checkOutput($sformatf("%s rdata", tag), dataObs, expRd);
      end else if (tbDrive) begin
        checkOutput($sformatf("%s data c%0d", tag, j), dataObs, tbData);
      end
      if (j == 0) begin
        addr = $urandom;
        be   = 4'($urandom);
        if (tbDrive) tbData = $urandom;
      end
      if (j == abortAt) begin
        en   = 1'b0;
        live = 1'b0;
      end
      if (j == resetAt) begin
        RES = 1'b1;
        #1;
        checkOutput($sformatf("%s reset rack", tag), 32'(rackObs), 32'd0);
        checkOutput($sformatf("%s reset wack", tag), 32'(wackObs), 32'd0);
        en = 1'b0; re = 1'b0; we = 1'b0;
        tbDrive = 1'b1; tbData = 32'd0;
        live = 1'b0;
        @(negedge CLK);
        RES = 1'b0;
      end
      if (j == lat) begin
        en = 1'b0; re = 1'b0; we = 1'b0;
        tbDrive = 1'b1; tbData = 32'd0;
      end
    end
    en = 1'b0; re = 1'b0; we = 1'b0;
    tbDrive = 1'b1; tbData = 32'd0;
    if (live && isWrite) begin
      model[key] = mergeBytes(model.exists(key) ? model[key] : 32'd0, d, b);
    end
  endtask

  initial begin
    int          op;
    int          idx;
    logic [31:0] a;

    RES = 1'b1; sel = 1'b0; en = 1'b0; re = 1'b0; we = 1'b0;
    be = 4'd0; addr = 32'd0; tbData = 32'd0; tbDrive = 1'b1;

    // Reset state of both instances.
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checkOutput($sformatf("reset%0d rack", s), 32'(rackObs), 32'd0);
      checkOutput($sformatf("reset%0d wack", s), 32'(wackObs), 32'd0);
      checkOutput($sformatf("reset%0d data", s), dataObs, tbData);
    end
    sel = 1'b0;
    repeat (3) @(negedge CLK);
    RES = 1'b0;

    // Full write then read back, WAIT=2.
    applyStimulus("wr10", 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, -1, -1, 1'b0, 32'd0);
    applyStimulus("rd10", 1'b1, 1'b0, 32'h10, 4'h0, 32'd0, -1, -1, 1'b1, 32'hDEADBEEF);

    // Single-lane write.
    applyStimulus("wr10be", 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, -1, -1, 1'b0, 32'd0);
    applyStimulus("rd10be", 1'b1, 1'b0, 32'h10, 4'h0, 32'd0, -1, -1, 1'b1, 32'hDEADAAEF);

    // Empty lane mask acknowledges without changing the word.
    applyStimulus("wr10nobe", 1'b0, 1'b1, 32'h10, 4'b0000, 32'h11111111, -1, -1, 1'b0, 32'd0);
    applyStimulus("rd10nobe", 1'b1, 1'b0, 32'h10, 4'h0, 32'd0, -1, -1, 1'b1, 32'hDEADAAEF);

    // Aborted write leaves the word alone.
    applyStimulus("wr20", 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, -1, -1, 1'b0, 32'd0);
    applyStimulus("wr20abort", 1'b0, 1'b1, 32'h20, 4'hF, 32'h12345678, 1, -1, 1'b0, 32'd0);
    applyStimulus("rd20", 1'b1, 1'b0, 32'h20, 4'h0, 32'd0, -1, -1, 1'b1, 32'h00000000);

    // RE and WE together behave as a write.
    applyStimulus("rwr40", 1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, -1, -1, 1'b0, 32'd0);
    applyStimulus("rd40", 1'b1, 1'b0, 32'h40, 4'h0, 32'd0, -1, -1, 1'b1, 32'hCAFEF00D);

    // EN with no operation is ignored.
    @(negedge CLK);
    en = 1'b1; re = 1'b0; we = 1'b0; addr = 32'h10; be = 4'hF;
    idleCycles("noop", 5);
    en = 1'b0;

    // Back-to-back reads with EN held: RACK after edges 3 and 7.
    @(negedge CLK);
    en = 1'b1; re = 1'b1; we = 1'b0; addr = 32'h10; tbDrive = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      checkOutput($sformatf("b2b rack c%0d", j), 32'(rackObs), 32'(j == 3 || j == 7));
      checkOutput($sformatf("b2b wack c%0d", j), 32'(wackObs), 32'd0);
      if (j == 3) checkOutput("b2b rdata first", dataObs, 32'hDEADAAEF);
      if (j == 7) checkOutput("b2b rdata second", dataObs, 32'hCAFEF00D);
      if (j == 1) addr = 32'h40;
      if (j == 7) begin
        en = 1'b0; re = 1'b0; tbDrive = 1'b1; tbData = 32'd0;
      end
    end
    en = 1'b0; re = 1'b0; tbDrive = 1'b1; tbData = 32'd0;

    // Reset in the middle of a write's wait period.
    applyStimulus("wr80", 1'b0, 1'b1, 32'h80, 4'hF, 32'hA5A5_5A5A, -1, -1, 1'b0, 32'd0);
    applyStimulus("wr80rst", 1'b0, 1'b1, 32'h80, 4'hF, 32'h0BAD_F00D, -1, 1, 1'b0, 32'd0);
    idleCycles("postrst", 4);
    applyStimulus("rd80", 1'b1, 1'b0, 32'h80, 4'h0, 32'd0, -1, -1, 1'b1, 32'hA5A5_5A5A);

    // Reset during the RACK cycle clears RACK immediately.
    applyStimulus("rd40rst", 1'b1, 1'b0, 32'h40, 4'h0, 32'd0, -1, 3, 1'b1, 32'hCAFEF00D);
    idleCycles("postrst2", 3);

    // WAIT=0 instance: wrapped address alias.
    sel = 1'b1;
    applyStimulus("z_rwr40", 1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, -1, -1, 1'b0, 32'd0);
    applyStimulus("z_rd1040", 1'b1, 1'b0, 32'h1040, 4'h0, 32'd0, -1, -1, 1'b1, 32'hCAFEF00D);

    // Randomized traffic on both instances against the word model.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 8; i++) begin
        pool[i] = 32'($urandom_range(0, WORDS - 1)) * 32'd4;
        applyStimulus($sformatf("rnd%0d init%0d", s, i), 1'b0, 1'b1, pool[i], 4'hF,
                      $urandom, -1, -1, 1'b0, 32'd0);
      end
      for (int i = 0; i < 25; i++) begin
        op  = int'($urandom_range(0, 3));
        idx = int'($urandom_range(0, 7));
        a   = pool[idx] + 32'($urandom_range(0, 15)) * 32'h1000 + 32'($urandom_range(0, 3));
        case (op)
          0, 1: applyStimulus($sformatf("rnd%0d rd%0d", s, i), 1'b1, 1'b0, a, 4'($urandom),
                              $urandom, -1, -1, 1'b0, 32'd0);
          2:    applyStimulus($sformatf("rnd%0d wr%0d", s, i), 1'b0, 1'b1, a, 4'($urandom),
                              $urandom, -1, -1, 1'b0, 32'd0);
          default: applyStimulus($sformatf("rnd%0d rw%0d", s, i), 1'b1, 1'b1, a, 4'($urandom),
                                 $urandom, -1, -1, 1'b0, 32'd0);
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        applyStimulus($sformatf("rnd%0d final%0d", s, i), 1'b1, 1'b0, pool[i], 4'h0,
                      32'd0, -1, -1, 1'b0, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
